neuron_mac_seq: RTL

Sequential, parametrised neuron engine for the MLP datapath. For a selected neuron it streams N_INPUTS activation/weight pairs from external synchronous memories and accumulates their signed fixed-point products at full precision. It then adds the neuron bias, requantises the sum to DATA_W with saturation, and applies an optional ReLU. One instance, re-parametrised, serves every layer (784→200, 200→50, 50→10); the result is returned over a valid/ready handshake.

---
 rtl/neuron_pkg.sv | 20 ++
 rtl/neuron_mac_seq_if.sv | 32 +++
 rtl/neuron_mac_seq_fx_requant.sv | 44 ++++
 rtl/neuron_mac_seq.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types, default widths and width helpers for the sequential neuron engine
// and its testbenches.
package neuron_pkg;

  typedef enum logic [2:0] {IDLE, MAC, DRAIN, BIAS, OUT} state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;

  // Full-precision accumulator width: product width plus growth for n_inputs terms plus bias headroom.
  function automatic int acc_width(input int data_w, input int n_inputs);
    return 2 * data_w + $clog2(n_inputs) + 1;
  endfunction

  // Address width for a table of n entries, never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/neuron_mac_seq_if.sv
// Bundle of the neuron engine's control, memory and result handshake signals.
// The master side is the engine; the slave side is the memories plus the consumer.
interface neuron_mac_seq_if #(
  parameter int DATA_W = 16,
  parameter int NEU_W  = 8,
  parameter int IN_W   = 10
);
  logic                  start;
  logic [NEU_W-1:0]      neuron_idx;
  logic                  busy;
  logic                  rd_en;
  logic [IN_W-1:0]       x_addr;
  logic [NEU_W+IN_W-1:0] w_addr;
  logic [DATA_W-1:0]     x_data;
  logic [DATA_W-1:0]     w_data;
  logic [NEU_W-1:0]      b_addr;
  logic [DATA_W-1:0]     b_data;
  logic [DATA_W-1:0]     out_data;
  logic                  out_sat;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    input  start, neuron_idx, x_data, w_data, b_data, out_ready,
    output busy, rd_en, x_addr, w_addr, b_addr, out_data, out_sat, out_valid
  );

  modport slave (
    output start, neuron_idx, x_data, w_data, b_data, out_ready,
    input  busy, rd_en, x_addr, w_addr, b_addr, out_data, out_sat, out_valid
  );
endinterface

// File: rtl/neuron_mac_seq_fx_requant.sv
// Combinational requantiser: drops FRAC_W fraction bits (floor), clips to DATA_W
// signed range and optionally clamps negatives to zero.
module fx_requant #(
  parameter int ACC_W   = 43,
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int RELU_EN = 1
) (
  input  logic signed [ACC_W-1:0] acc_in,
  output logic [DATA_W-1:0]       data_out,
  output logic                    sat_out
);

  logic signed [ACC_W-1:0]  shifted;
  logic [ACC_W-DATA_W:0]    top_bits;
  logic                     sat_hi;
  logic                     sat_lo;
  logic [DATA_W-1:0]        clipped;

  assign shifted  = acc_in >>> FRAC_W;
  // Value fits iff every bit from the DATA_W sign position upwards agrees.
  assign top_bits = shifted[ACC_W-1:DATA_W-1];
  assign sat_hi   = !top_bits[ACC_W-DATA_W] && (|top_bits);
  assign sat_lo   = top_bits[ACC_W-DATA_W] && !(&top_bits);
  assign sat_out  = sat_hi | sat_lo;

  always_comb begin
    clipped = shifted[DATA_W-1:0];
    if (sat_hi) begin
      clipped = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (sat_lo) begin
      clipped = {1'b1, {(DATA_W-1){1'b0}}};
    end
  end

  generate
    if (RELU_EN != 0) begin : g_relu
      assign data_out = clipped[DATA_W-1] ? '0 : clipped;
    end else begin : g_pass
      assign data_out = clipped;
    end
  endgenerate

endmodule

// File: rtl/neuron_mac_seq.sv
// Sequential neuron engine: streams N_INPUTS x/w pairs from one-cycle-latency memories,
// accumulates at full precision, adds the bias, requantises and hands the result over.
module neuron_mac_seq
  import neuron_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAC_W    = DEF_FRAC_W,
  parameter int N_INPUTS  = 784,
  parameter int N_NEURONS = 200,
  parameter int RELU_EN   = 1
) (
  input  logic           clk,
  input  logic           reset,
  neuron_mac_seq_if.master bus
);

  localparam int IN_W   = addr_width(N_INPUTS);
  localparam int NEU_W  = addr_width(N_NEURONS);
  localparam int ACC_W  = acc_width(DATA_W, N_INPUTS);
  localparam int PROD_W = 2 * DATA_W;
  localparam logic [IN_W-1:0] LAST_ADDR = IN_W'(N_INPUTS - 1);

  state_t                   state_reg, state_next;
  logic [IN_W-1:0]          x_addr_reg, x_addr_next;
  logic [NEU_W-1:0]         idx_reg, idx_next;
  logic signed [ACC_W-1:0]  acc_reg, acc_next;
  logic                     mac_valid_reg;
  logic                     rd_en_reg, rd_en_next;
  logic                     busy_reg, busy_next;
  logic [DATA_W-1:0]        out_data_reg, out_data_next;
  logic                     out_sat_reg, out_sat_next;
  logic                     out_valid_reg, out_valid_next;

  logic signed [PROD_W-1:0] x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]  prod_ext, bias_ext, acc_biased;
  logic [DATA_W-1:0]        rq_data;
  logic                     rq_sat;

  assign x_ext    = {{DATA_W{bus.x_data[DATA_W-1]}}, bus.x_data};
  assign w_ext    = {{DATA_W{bus.w_data[DATA_W-1]}}, bus.w_data};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  // Bias is aligned to the product's 2*FRAC_W fraction before being added.
  assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){bus.b_data[DATA_W-1]}}, bus.b_data, {FRAC_W{1'b0}}};
  assign acc_biased = acc_reg + bias_ext;

  fx_requant #(
    .ACC_W   (ACC_W),
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W),
    .RELU_EN (RELU_EN)
  ) u_requant (
    .acc_in   (acc_biased),
    .data_out (rq_data),
    .sat_out  (rq_sat)
  );

  always_comb begin
    state_next     = state_reg;
    x_addr_next    = x_addr_reg;
    idx_next       = idx_reg;
    acc_next       = acc_reg;
    out_data_next  = out_data_reg;
    out_sat_next   = out_sat_reg;
    out_valid_next = out_valid_reg;
    // Data for a read issued last cycle arrives now, independent of the current state.
    if (mac_valid_reg) begin
      acc_next = acc_reg + prod_ext;
    end
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next  = MAC;
          idx_next    = bus.neuron_idx;
          acc_next    = '0;
          x_addr_next = '0;
        end
      end
      MAC: begin
        if (x_addr_reg == LAST_ADDR) begin
          state_next = DRAIN;
        end else begin
          x_addr_next = x_addr_reg + IN_W'(1);
        end
      end
      DRAIN: state_next = BIAS;
      BIAS: begin
        acc_next       = acc_biased;
        out_data_next  = rq_data;
        out_sat_next   = rq_sat;
        out_valid_next = 1'b1;
        state_next     = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    rd_en_next = (state_next == MAC);
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      x_addr_reg    <= '0;
      idx_reg       <= '0;
      acc_reg       <= '0;
      mac_valid_reg <= 1'b0;
      rd_en_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      x_addr_reg    <= x_addr_next;
      idx_reg       <= idx_next;
      acc_reg       <= acc_next;
      mac_valid_reg <= rd_en_reg;
      rd_en_reg     <= rd_en_next;
      busy_reg      <= busy_next;
      out_data_reg  <= out_data_next;
      out_sat_reg   <= out_sat_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign bus.busy      = busy_reg;
  assign bus.rd_en     = rd_en_reg;
  assign bus.x_addr    = x_addr_reg;
  assign bus.w_addr    = {idx_reg, x_addr_reg};
  assign bus.b_addr    = idx_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sat   = out_sat_reg;
  assign bus.out_valid = out_valid_reg;

endmodule
